block_config_loader: RTL
========================

BLOCK_CONFIG_LOADER -- requirements
Module: block_config_loader

Interface
REQ-001 Parameter ADDR_BITS, default 4, SHALL set the address width of the downstream LUT config memory.
REQ-002 Parameter MEM_SIZE, default 2**ADDR_BITS, SHALL set config frame length in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 cfg_start  input  1  SHALL request a new frame load.
REQ-006 cfg_bit  input  1  SHALL carry the serial config data bit.
REQ-007 cfg_valid  input  1  SHALL qualify cfg_bit.
REQ-008 cfg_ready  output  1  SHALL indicate a bit is accepted this cycle when cfg_valid=1.
REQ-009 config_in  output  MEM_SIZE  SHALL drive the parallel frame into the config latch block.
REQ-010 comb_set  output  1  SHALL be the load strobe to the config latch block.
REQ-011 busy  output  1  SHALL be high in any state other than IDLE.
REQ-012 done  output  1  SHALL flag that a frame has been committed.
REQ-013 cfg_err  output  1  SHALL flag a rejected frame.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, PARITY (macro only), COMMIT.
REQ-015 IDLE: cfg_ready=0, comb_set=0; cfg_start=1 -> SHIFT, bit counter=0, shift register=0, done=0, cfg_err=0.
REQ-016 SHIFT: cfg_ready=1; on cfg_valid=1, shift register SHALL shift right, cfg_bit entering bit MEM_SIZE-1, counter+1.
REQ-017 Bit ordering: first accepted bit SHALL land in config_in[0], last in config_in[MEM_SIZE-1].
REQ-018 cfg_valid=0 cycles in SHIFT SHALL stall with no state change; no timeout.
REQ-019 Acceptance of bit MEM_SIZE-1 SHALL transition SHIFT -> COMMIT (or -> PARITY with macro).
REQ-020 Entry to COMMIT SHALL load config_in from the shift register; config_in SHALL hold otherwise.
REQ-021 COMMIT: comb_set=1 for exactly one cycle, cfg_ready=0; next state IDLE with done=1.
REQ-022 Latency: last data bit accepted in cycle N -> comb_set=1 in cycle N+1 (N+2 with parity bit).
REQ-023 config_in SHALL be stable throughout the comb_set cycle and the cycle after it.
REQ-024 done SHALL stay high until next accepted cfg_start or rst.
REQ-025 cfg_start in SHIFT or PARITY SHALL restart the frame: counter=0, shift register=0, partial bits discarded, config_in unchanged; the concurrent cfg_bit is not accepted.
REQ-026 cfg_start in COMMIT SHALL be ignored; commit completes.
REQ-027 Counter SHALL be $clog2(MEM_SIZE)+1 bits wide and never wrap within a frame.
REQ-028 cfg_valid outside SHIFT/PARITY SHALL be ignored.

Reset
REQ-029 rst=1 SHALL force IDLE, counter=0, shift register=0, config_in=0, comb_set=0, cfg_ready=0, busy=0, done=0, cfg_err=0.
REQ-030 rst SHALL override every other input, including mid-frame and during COMMIT (comb_set low on next edge).

Configuration
REQ-031 Macro BLOCK_CONFIG_LOADER_PARITY_EN defined: after MEM_SIZE data bits, PARITY accepts one more bit (cfg_ready=1); XOR of all data bits and parity bit ==0 -> COMMIT; else -> IDLE, cfg_err=1, no comb_set, config_in unchanged.
REQ-032 Macro undefined: PARITY state absent, SHIFT -> COMMIT directly, cfg_err tied 0.

Verification
REQ-033 MEM_SIZE=16, cfg_start, 16 bits of 0xA5C3 LSB-first, cfg_valid continuous -> single comb_set pulse, config_in=16'hA5C3, done=1.
REQ-034 Same frame with cfg_valid low every other cycle -> identical config_in, comb_set one cycle after last bit, no extra pulses.
REQ-035 After 7 bits of 0xFFFF, cfg_start, then full frame 0x0001 -> config_in=16'h0001, exactly one comb_set.
REQ-036 rst at bit 10 of a frame -> all outputs 0 next cycle, no comb_set, previous config_in cleared to 0.
REQ-037 Macro on: 0x0003 + parity 0 -> commit 16'h0003; 0x0003 + parity 1 -> cfg_err=1, no comb_set, config_in unchanged.
REQ-038 cfg_start asserted in COMMIT cycle -> comb_set still one cycle, FSM returns to IDLE, done=1.

Source files
------------

// File: rtl/block_config_loader.sv
// Serial-to-parallel config frame loader: shifts MEM_SIZE bits LSB-first, then strobes comb_set.
// Define BLOCK_CONFIG_LOADER_PARITY_EN to require a trailing even-parity bit before commit.
module block_config_loader #(
  parameter int ADDR_BITS = 4,
  parameter int MEM_SIZE  = 2**ADDR_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_bit,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [MEM_SIZE-1:0] config_in,
  output logic                comb_set,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  // state  | meaning
  // IDLE   | waiting for cfg_start; done/cfg_err report the last frame
  // SHIFT  | accepting MEM_SIZE data bits, first bit ends up in config_in[0]
  // PARITY | accepting the trailing parity bit (parity build only)
  // COMMIT | config_in already loaded; comb_set strobes for this one cycle

  localparam int CNT_W = $clog2(MEM_SIZE) + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef BLOCK_CONFIG_LOADER_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif
  localparam logic [1:0] COMMIT = 2'd3;

  logic [1:0]          state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [MEM_SIZE-1:0] shift_reg;
  logic [MEM_SIZE-1:0] shift_nxt;
  logic                last_bit;

  assign shift_nxt = {cfg_bit, shift_reg[MEM_SIZE-1:1]};
  assign last_bit  = (bit_cnt == CNT_W'(MEM_SIZE - 1));

`ifdef BLOCK_CONFIG_LOADER_PARITY_EN
  logic err_q;
  assign cfg_err = err_q;
`else
  assign cfg_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      config_in <= '0;
      done      <= 1'b0;
`ifdef BLOCK_CONFIG_LOADER_PARITY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            shift_reg <= '0;
            done      <= 1'b0;
`ifdef BLOCK_CONFIG_LOADER_PARITY_EN
            err_q     <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          // a restart wins over a concurrent data bit, which is dropped
          if (cfg_start) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
          end else if (cfg_valid) begin
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt + CNT_W'(1);
            if (last_bit) begin
`ifdef BLOCK_CONFIG_LOADER_PARITY_EN
              state     <= PARITY;
`else
              state     <= COMMIT;
              config_in <= shift_nxt;
`endif
            end
          end
        end
`ifdef BLOCK_CONFIG_LOADER_PARITY_EN
        PARITY: begin
          if (cfg_start) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end else if (cfg_valid) begin
            if ((^shift_reg ^ cfg_bit) == 1'b0) begin
              state     <= COMMIT;
              config_in <= shift_reg;
            end else begin
              state <= IDLE;
              err_q <= 1'b1;
            end
          end
        end
`endif
        COMMIT: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_ready = (state == SHIFT);
`ifdef BLOCK_CONFIG_LOADER_PARITY_EN
    if (state == PARITY) cfg_ready = 1'b1;
`endif
    comb_set = (state == COMMIT);
    busy     = (state != IDLE);
  end

endmodule
